// File: rtl/lbm_stream_bounce_engine.sv
// D2Q9 lattice-Boltzmann streaming engine: pull streaming fused with halfway
// bounce-back, ping-pong banks per direction, host word port usable while idle.
module lbm_stream_bounce_engine #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int WRAP_X     = 1,
    parameter int WRAP_Y     = 1,
    parameter int STEP_WIDTH = 8,
    parameter int N          = WIDTH * HEIGHT,
    parameter int AW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STEP_WIDTH-1:0] n_steps,
    output logic                  busy,
    output logic                  done,
    input  logic [3:0]            host_sel,
    input  logic [AW-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  host_we,
    input  logic                  host_re,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    fb_r;
    logic [STEP_WIDTH-1:0]   steps_r;
    logic [AW-1:0]           d_r;
    logic [XW-1:0]           x_r;
    logic [YW-1:0]           y_r;
    logic                    wr_en_r;
    logic [AW-1:0]           wr_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r [0:8];
    logic [DATA_WIDTH-1:0]   val_s     [0:8];
    logic [AW:0]             src_s     [0:8];
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   host_rdata_r;
    logic                    host_rvalid_r;
    logic                    addr_ok_s;
    logic                    host_wr_s;
    logic                    host_rd_s;

    logic [DATA_WIDTH-1:0]   pop_mem     [0:8][0:1][0:N-1];
    logic                    barrier_mem [0:N-1];

    function automatic int dir_dx(input int dir);
        case (dir)
            2, 3, 4: dir_dx = 1;
            6, 7, 8: dir_dx = -1;
            default: dir_dx = 0;
        endcase
    endfunction

    // Positive dy points south (y+1); north is y-1.
    function automatic int dir_dy(input int dir);
        case (dir)
            1, 2, 8: dir_dy = -1;
            4, 5, 6: dir_dy = 1;
            default: dir_dy = 0;
        endcase
    endfunction

    function automatic int dir_opp(input int dir);
        dir_opp = (dir > 4) ? dir - 4 : dir + 4;
    endfunction

    // Returns {outside, address} of the upstream cell d - c_dir using only add/sub.
    function automatic logic [AW:0] pull_src(input int dir, input logic [AW-1:0] d,
                                             input logic [XW-1:0] x, input logic [YW-1:0] y);
        int   a;
        logic out;
        a   = int'(d);
        out = 1'b0;
        if (dir_dx(dir) == 1) begin
            if (int'(x) == 0) begin
                if (WRAP_X != 0) a = a + (WIDTH - 1);
                else             out = 1'b1;
            end else begin
                a = a - 1;
            end
        end else if (dir_dx(dir) == -1) begin
            if (int'(x) == WIDTH - 1) begin
                if (WRAP_X != 0) a = a - (WIDTH - 1);
                else             out = 1'b1;
            end else begin
                a = a + 1;
            end
        end
        if (dir_dy(dir) == 1) begin
            if (int'(y) == 0) begin
                if (WRAP_Y != 0) a = a + (N - WIDTH);
                else             out = 1'b1;
            end else begin
                a = a - WIDTH;
            end
        end else if (dir_dy(dir) == -1) begin
            if (int'(y) == HEIGHT - 1) begin
                if (WRAP_Y != 0) a = a - (N - WIDTH);
                else             out = 1'b1;
            end else begin
                a = a + WIDTH;
            end
        end
        pull_src = {out, a[AW-1:0]};
    endfunction

    assign addr_ok_s = (int'(host_addr) < N);
    assign host_wr_s = host_we && (state_r == S_IDLE) && addr_ok_s;
    assign host_rd_s = host_re && (state_r == S_IDLE);

    // Next-state logic for the run sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && (n_steps != '0)) state_s = S_RUN;
                else                          state_s = S_IDLE;
            end
            S_RUN: begin
                if (int'(d_r) == N - 1) state_s = S_DRAIN;
                else                    state_s = S_RUN;
            end
            S_DRAIN: state_s = S_SWAP;
            S_SWAP: begin
                if (steps_r == STEP_WIDTH'(1)) state_s = S_IDLE;
                else                           state_s = S_RUN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Fused stream/bounce-back selection for destination cell d_r.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            src_s[i] = pull_src(i, d_r, x_r, y_r);
            if (barrier_mem[d_r]) begin
                val_s[i] = '0;
            end else if (i == 0) begin
                val_s[i] = pop_mem[0][fb_r][d_r];
            end else if (src_s[i][AW]) begin
                val_s[i] = pop_mem[i][fb_r][d_r];
            end else if (barrier_mem[src_s[i][AW-1:0]]) begin
                val_s[i] = pop_mem[dir_opp(i)][fb_r][d_r];
            end else begin
                val_s[i] = pop_mem[i][fb_r][src_s[i][AW-1:0]];
            end
        end
    end

    // Sweep counters, step count, buffer select and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_r      <= 1'b0;
            steps_r   <= '0;
            d_r       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r    <= (state_s != S_IDLE);
            done_r    <= ((state_r == S_IDLE) && start && (n_steps == '0)) ||
                         ((state_r == S_SWAP) && (steps_r == STEP_WIDTH'(1)));
            wr_en_r   <= (state_r == S_RUN);
            wr_addr_r <= d_r;
            if ((state_r == S_IDLE) && start) begin
                steps_r <= n_steps;
            end else if (state_r == S_SWAP) begin
                steps_r <= steps_r - STEP_WIDTH'(1);
            end
            if (state_r == S_SWAP) begin
                fb_r <= ~fb_r;
            end
            if (state_r == S_RUN) begin
                d_r <= d_r + AW'(1);
                if (int'(x_r) == WIDTH - 1) begin
                    x_r <= '0;
                    y_r <= y_r + YW'(1);
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end else begin
                d_r <= '0;
                x_r <= '0;
                y_r <= '0;
            end
        end
    end

    // Pipeline data register feeding the back-buffer write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            wr_data_r[i] <= val_s[i];
        end
    end

    // Population banks: engine writes the back buffer, host writes the front one.
    always_ff @(posedge clk) begin
        if (wr_en_r) begin
            for (int i = 0; i < 9; i++) begin
                pop_mem[i][~fb_r][wr_addr_r] <= wr_data_r[i];
            end
        end else if (host_wr_s && (host_sel < 4'd9)) begin
            pop_mem[host_sel][fb_r][host_addr] <= host_wdata;
        end
    end

    // Barrier map is single-buffered and only changes through the host.
    always_ff @(posedge clk) begin
        if (host_wr_s && (host_sel == 4'd9)) begin
            barrier_mem[host_addr] <= host_wdata[0];
        end
    end

    // Host read port, one-cycle latency, returns pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata_r  <= '0;
            host_rvalid_r <= 1'b0;
        end else if (host_rd_s) begin
            host_rvalid_r <= 1'b1;
            if (!addr_ok_s) begin
                host_rdata_r <= '0;
            end else if (host_sel < 4'd9) begin
                host_rdata_r <= pop_mem[host_sel][fb_r][host_addr];
            end else if (host_sel == 4'd9) begin
                host_rdata_r <= {{(DATA_WIDTH-1){1'b0}}, barrier_mem[host_addr]};
            end else begin
                host_rdata_r <= '0;
            end
        end else begin
            host_rvalid_r <= 1'b0;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign host_rdata  = host_rdata_r;
    assign host_rvalid = host_rvalid_r;

endmodule

// File: tb/tb_lbm_stream_bounce_engine.sv
// Directed bench: a periodic-x instance and a closed-x instance driven in lockstep.
module tb_lbm_stream_bounce_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  n_steps;
    logic [3:0]  host_sel;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_we;
    logic        host_re;
    logic        busy_w, done_w, rvalid_w;
    logic        busy_c, done_c, rvalid_c;
    logic [15:0] rdata_w, rdata_c;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          dn;

    always #5 clk = ~clk;

    lbm_stream_bounce_engine #(
        .WIDTH(4), .HEIGHT(3), .DATA_WIDTH(16), .WRAP_X(1), .WRAP_Y(1), .STEP_WIDTH(8)
    ) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .n_steps(n_steps),
        .busy(busy_w), .done(done_w),
        .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_re(host_re),
        .host_rdata(rdata_w), .host_rvalid(rvalid_w)
    );

    lbm_stream_bounce_engine #(
        .WIDTH(4), .HEIGHT(3), .DATA_WIDTH(16), .WRAP_X(0), .WRAP_Y(1), .STEP_WIDTH(8)
    ) dut_closed (
        .clk(clk), .rst(rst), .start(start), .n_steps(n_steps),
        .busy(busy_c), .done(done_c),
        .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_re(host_re),
        .host_rdata(rdata_c), .host_rvalid(rvalid_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] sel, input logic [3:0] addr, input logic [15:0] data);
        host_sel   = sel;
        host_addr  = addr;
        host_wdata = data;
        host_we    = 1'b1;
        @(negedge clk);
        host_we    = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [3:0] sel, input logic [3:0] addr,
                               input logic [15:0] exp_w, input logic [15:0] exp_c);
        host_sel  = sel;
        host_addr = addr;
        host_re   = 1'b1;
        @(negedge clk);
        host_re   = 1'b0;
        check_val({tag, "_wrap"}, 32'(rdata_w), 32'(exp_w));
        check_val({tag, "_closed"}, 32'(rdata_c), 32'(exp_c));
    endtask

    task automatic clear_front();
        for (int s = 0; s < 10; s++) begin
            for (int a = 0; a < 12; a++) begin
                host_write(4'(s), 4'(a), 16'h0000);
            end
        end
    endtask

    task automatic run_steps(input logic [7:0] k, output int cycles);
        n_steps = k;
        start   = 1'b1;
        cycles  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end while (!done_w && cycles < 300);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_steps = 8'd0;
        host_sel = 4'd0; host_addr = 4'd0; host_wdata = 16'h0000;
        host_we = 1'b0; host_re = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy_w | busy_c), 32'd0);
        check_val("rst_done", 32'(done_w | done_c), 32'd0);
        check_val("rst_rdata", 32'(rdata_w | rdata_c), 32'd0);
        check_val("rst_rvalid", 32'(rvalid_w | rvalid_c), 32'd0);
        rst = 1'b0;

        // Host port: write/read, latency, read-during-write, unused select.
        clear_front();
        host_write(4'd3, 4'd5, 16'h1234);
        host_sel = 4'd3; host_addr = 4'd5; host_re = 1'b1;
        @(negedge clk);
        host_re = 1'b0;
        check_val("rd_rvalid", 32'(rvalid_w), 32'd1);
        check_val("rd_data", 32'(rdata_w), 32'h1234);
        @(negedge clk);
        check_val("rd_rvalid_drop", 32'(rvalid_w), 32'd0);
        host_wdata = 16'h5678; host_we = 1'b1; host_re = 1'b1;
        @(negedge clk);
        host_we = 1'b0; host_re = 1'b0;
        check_val("rw_old_data", 32'(rdata_w), 32'h1234);
        read_expect("rw_new_data", 4'd3, 4'd5, 16'h5678, 16'h5678);
        host_write(4'd12, 4'd5, 16'hBEEF);
        read_expect("sel12_zero", 4'd12, 4'd5, 16'h0000, 16'h0000);

        // Single periodic step.
        clear_front();
        host_write(4'd3, 4'd5, 16'd100);
        run_steps(8'd1, cyc);
        check_val("stream_latency", 32'(cyc), 32'd15);
        check_val("stream_done_closed", 32'(done_c), 32'd1);
        @(negedge clk);
        check_val("stream_done_pulse", 32'(done_w), 32'd0);
        read_expect("stream_a6", 4'd3, 4'd6, 16'd100, 16'd100);
        read_expect("stream_a5", 4'd3, 4'd5, 16'd0, 16'd0);

        // East edge: wraps on one instance, lost on the other.
        clear_front();
        host_write(4'd3, 4'd7, 16'd100);
        run_steps(8'd1, cyc);
        check_val("edge_latency", 32'(cyc), 32'd15);
        read_expect("edge_a4", 4'd3, 4'd4, 16'd100, 16'd0);
        read_expect("edge_a7", 4'd3, 4'd7, 16'd0, 16'd0);

        // Bounce-back off a barrier at addr 6.
        clear_front();
        host_write(4'd9, 4'd6, 16'd1);
        host_write(4'd3, 4'd5, 16'd100);
        run_steps(8'd1, cyc);
        check_val("bounce_latency", 32'(cyc), 32'd15);
        read_expect("bounce_w5", 4'd7, 4'd5, 16'd100, 16'd100);
        read_expect("bounce_e5", 4'd3, 4'd5, 16'd0, 16'd0);
        for (int b = 0; b < 9; b++) begin
            read_expect($sformatf("bounce_b%0d_a6", b), 4'(b), 4'd6, 16'd0, 16'd0);
        end
        read_expect("barrier_read", 4'd9, 4'd6, 16'd1, 16'd1);

        // Three steps, then a zero-step start.
        clear_front();
        host_write(4'd3, 4'd4, 16'd7);
        run_steps(8'd3, cyc);
        check_val("multi_latency", 32'(cyc), 32'd43);
        read_expect("multi_a7", 4'd3, 4'd7, 16'd7, 16'd7);
        run_steps(8'd0, cyc);
        check_val("zero_latency", 32'(cyc), 32'd1);
        check_val("zero_busy", 32'(busy_w), 32'd0);
        read_expect("zero_a7", 4'd3, 4'd7, 16'd7, 16'd7);

        // start and host_we while busy must be ignored.
        clear_front();
        host_write(4'd3, 4'd5, 16'd100);
        n_steps = 8'd1; start = 1'b1; cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0; host_we = 1'b0;
            cyc++;
            if (cyc == 3) begin
                check_val("robust_busy", 32'(busy_w), 32'd1);
                start = 1'b1; n_steps = 8'd5;
                host_sel = 4'd3; host_addr = 4'd6; host_wdata = 16'hFFFF; host_we = 1'b1;
            end
        end while (!done_w && cyc < 300);
        check_val("robust_latency", 32'(cyc), 32'd15);
        read_expect("robust_a6", 4'd3, 4'd6, 16'd100, 16'd100);
        read_expect("robust_a5", 4'd3, 4'd5, 16'd0, 16'd0);
        read_expect("robust_a7", 4'd3, 4'd7, 16'd0, 16'd0);

        // Reset during RUN with fb=1: must land back on buffer 0, no done.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_front();
        host_write(4'd0, 4'd11, 16'h0AAA);
        run_steps(8'd1, cyc);
        host_write(4'd0, 4'd11, 16'h0BBB);
        n_steps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_busy_before", 32'(busy_w), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", 32'(busy_w | busy_c), 32'd0);
        check_val("midrst_done", 32'(done_w | done_c), 32'd0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_w || done_c) dn++;
        end
        check_val("midrst_no_done", 32'(dn), 32'd0);
        read_expect("midrst_fb0", 4'd0, 4'd11, 16'h0AAA, 16'h0AAA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
